// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch slice: bus widths, FSM encoding
// and the PC legality rule used by both redirect handling and sequential fetch.
package fetch_unit_pkg;

  localparam int API_ADDR_WIDTH = 32;
  localparam int API_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  // A PC is fetchable when word aligned and the whole word lies inside the ROM.
  function automatic logic pc_is_legal(input logic [API_ADDR_WIDTH-1:0] pc,
                                       input int unsigned             rom_bytes);
    return (pc[1:0] == 2'b00) && (pc <= API_ADDR_WIDTH'(rom_bytes - 4));
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: circular FIFO with push, pop and flush, pointers wrapping
// modulo DEPTH so non-power-of-two depths work.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] count_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop_i && (count_q != '0) && !flush_i;
  assign do_push = push_i && !flush_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage has no reset; count_q gates every read, so stale contents
  // are never observable and the array can map onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues sequential ROM reads, buffers responses
// with their PCs, and handles redirects and out-of-range/misaligned faults.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [API_ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned               ROM_BYTES  = 8192,
  parameter int                        FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  output logic                      rom_en_o,
  output logic [API_ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [API_DATA_WIDTH-1:0] rom_data_i,
  input  logic                      redirect_i,
  input  logic [API_ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                      instr_valid_o,
  input  logic                      instr_ready_i,
  output logic [API_DATA_WIDTH-1:0] instr_o,
  output logic [API_ADDR_WIDTH-1:0] instr_pc_o,
  output logic                      fault_o
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int ENTRY_W = API_DATA_WIDTH + API_ADDR_WIDTH;

  fetch_state_e              state_q, state_d;
  logic [API_ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [API_ADDR_WIDTH-1:0] inflight_pc_q;
  logic                      inflight_q, inflight_d;
  logic [CNT_W-1:0]          fifo_count;
  logic [ENTRY_W-1:0]        fifo_head;
  logic                      pc_legal, has_room, fifo_pop;

  assign pc_legal = pc_is_legal(pc_q, ROM_BYTES);
  // Counting the in-flight response reserves its slot, so the FIFO cannot overflow.
  assign has_room = (int'(fifo_count) + int'(inflight_q)) < FIFO_DEPTH;

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inflight_d = 1'b0;
    rom_en_o   = (state_q == ST_RUN) && pc_legal && has_room && !redirect_i;
    fault_o    = (state_q == ST_FAULT);

    unique case (state_q)
      ST_IDLE:  state_d = ST_RUN;
      ST_RUN:   if (!pc_legal && (fifo_count == '0) && !inflight_q) state_d = ST_FAULT;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase

    if (rom_en_o) begin
      pc_d       = pc_q + API_ADDR_WIDTH'(4);
      inflight_d = 1'b1;
    end

    if (redirect_i) begin
      pc_d       = redirect_pc_i;
      inflight_d = 1'b0;
      state_d    = pc_is_legal(redirect_pc_i, ROM_BYTES) ? ST_RUN : ST_FAULT;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      if (rom_en_o) inflight_pc_q <= pc_q;
    end
  end

  assign rom_addr_o = pc_q;
  assign fifo_pop   = instr_valid_o && instr_ready_i;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (inflight_q),
    .push_data_i ({inflight_pc_q, rom_data_i}),
    .pop_i       (fifo_pop),
    .flush_i     (redirect_i),
    .count_o     (fifo_count),
    .head_o      (fifo_head)
  );

  assign instr_valid_o              = (fifo_count != '0);
  assign {instr_pc_o, instr_o}      = fifo_head;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed timing scenarios plus a random
// stream compared against an outstanding-count model of the fetch rules.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          ROM_BYTES  = 8192;
  localparam int          FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rom_en_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i = 32'hDEAD_BEEF;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        fault_o;

  int n_checks = 0;
  int n_errors = 0;

  logic        s_en, s_valid, s_fault;
  logic [31:0] s_addr, s_instr, s_pc;

  fetch_unit #(
    .RESET_PC   (RESET_PC),
    .ROM_BYTES  (ROM_BYTES),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rom_en_o      (rom_en_o),
    .rom_addr_o    (rom_addr_o),
    .rom_data_i    (rom_data_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .fault_o       (fault_o)
  );

  always #5 clk = ~clk;

  // ROM word k holds value k.
  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    return addr >> 2;
  endfunction

  // Synchronous ROM: data valid the cycle after a request, junk otherwise.
  always @(posedge clk) rom_data_i <= rom_en_o ? rom_word(rom_addr_o) : 32'hDEAD_BEEF;

  // Drive one cycle's inputs at the falling edge, then sample outputs.
  task automatic drive(input logic rdy, input logic redir, input logic [31:0] rpc);
    @(negedge clk);
    instr_ready_i = rdy;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    #1;
    s_en    = rom_en_o;
    s_addr  = rom_addr_o;
    s_valid = instr_valid_o;
    s_instr = instr_o;
    s_pc    = instr_pc_o;
    s_fault = fault_o;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; instr_ready_i = 1'b1; redirect_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (rom_en_o !== 1'b0) begin n_errors++; $display("FAIL reset_rom_en: got %b, expected 0", rom_en_o); end
    n_checks++;
    if (rom_addr_o !== RESET_PC) begin n_errors++; $display("FAIL reset_rom_addr: got %h, expected %h", rom_addr_o, RESET_PC); end
    n_checks++;
    if (instr_valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b, expected 0", instr_valid_o); end
    n_checks++;
    if (fault_o !== 1'b0) begin n_errors++; $display("FAIL reset_fault: got %b, expected 0", fault_o); end
  endtask

  // Releases reset; cycle 1 is IDLE, issue from cycle 2, delivery from cycle 4.
  task automatic test_startup;
    logic [31:0] e_addr, e_pc;
    @(negedge clk);
    reset_n = 1'b1; instr_ready_i = 1'b1; redirect_i = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      if (i > 1) @(negedge clk);
      #1;
      e_addr = 32'(4 * (i - 2));
      e_pc   = 32'(4 * (i - 4));
      n_checks++;
      if (i == 1 && rom_en_o !== 1'b0) begin
        n_errors++; $display("FAIL startup_idle cyc%0d: rom_en=%b, expected 0", i, rom_en_o);
      end else if (i > 1 && (rom_en_o !== 1'b1 || rom_addr_o !== e_addr)) begin
        n_errors++; $display("FAIL startup_issue cyc%0d: en=%b addr=%h, expected en=1 addr=%h", i, rom_en_o, rom_addr_o, e_addr);
      end
      n_checks++;
      if (i < 4 && instr_valid_o !== 1'b0) begin
        n_errors++; $display("FAIL startup_early cyc%0d: valid=%b, expected 0", i, instr_valid_o);
      end else if (i >= 4 && (instr_valid_o !== 1'b1 || instr_o !== rom_word(e_pc) || instr_pc_o !== e_pc)) begin
        n_errors++; $display("FAIL startup_deliver cyc%0d: valid=%b instr=%h pc=%h, expected 1 %h %h",
                             i, instr_valid_o, instr_o, instr_pc_o, rom_word(e_pc), e_pc);
      end
    end
  endtask

  task automatic test_backpressure;
    int          issued;
    logic [31:0] e_pc, e_addr;
    drive(1'b0, 1'b1, 32'h200);
    issued = 0;
    for (int i = 1; i <= 10; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      if (s_en) begin
        e_addr = 32'h200 + 32'(4 * issued);
        n_checks++;
        if (s_addr !== e_addr) begin n_errors++; $display("FAIL stall_issue_addr: got %h, expected %h", s_addr, e_addr); end
        issued++;
      end
      if (i >= 3) begin
        n_checks++;
        if (s_valid !== 1'b1 || s_pc !== 32'h200 || s_instr !== rom_word(32'h200)) begin
          n_errors++; $display("FAIL stall_hold cyc%0d: valid=%b pc=%h instr=%h, expected 1 200 %h", i, s_valid, s_pc, s_instr, rom_word(32'h200));
        end
      end
    end
    n_checks++;
    if (issued != FIFO_DEPTH) begin n_errors++; $display("FAIL stall_issue_count: got %0d, expected %0d", issued, FIFO_DEPTH); end
    n_checks++;
    if (s_en !== 1'b0) begin n_errors++; $display("FAIL stall_full_en: got %b, expected 0", s_en); end
    e_pc = 32'h200;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 32'h0);
      n_checks++;
      if (s_valid !== 1'b1 || s_pc !== e_pc || s_instr !== rom_word(e_pc)) begin
        n_errors++; $display("FAIL release_stream #%0d: valid=%b pc=%h instr=%h, expected 1 %h %h", i, s_valid, s_pc, s_instr, e_pc, rom_word(e_pc));
      end
      e_pc += 32'd4;
    end
  endtask

  task automatic test_redirect_inflight;
    drive(1'b1, 1'b1, 32'h40);
    repeat (6) drive(1'b1, 1'b0, 32'h0);
    n_checks++;
    if (s_en !== 1'b1) begin n_errors++; $display("FAIL redir_setup_en: got %b, expected 1", s_en); end
    drive(1'b1, 1'b1, 32'h100);
    n_checks++;
    if (s_en !== 1'b0) begin n_errors++; $display("FAIL redir_priority_en: got %b, expected 0", s_en); end
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 1'b0, 32'h0);
      if (k == 1) begin
        n_checks++;
        if (s_en !== 1'b1 || s_addr !== 32'h100) begin n_errors++; $display("FAIL redir_issue: en=%b addr=%h, expected 1 100", s_en, s_addr); end
      end
      n_checks++;
      if (k < 3 && s_valid !== 1'b0) begin
        n_errors++; $display("FAIL redir_stale +%0d: valid=%b pc=%h, expected valid 0", k, s_valid, s_pc);
      end else if (k == 3 && (s_valid !== 1'b1 || s_pc !== 32'h100 || s_instr !== rom_word(32'h100))) begin
        n_errors++; $display("FAIL redir_first: valid=%b pc=%h instr=%h, expected 1 100 %h", s_valid, s_pc, s_instr, rom_word(32'h100));
      end
    end
  endtask

  task automatic test_fault;
    drive(1'b1, 1'b1, 32'h102);
    n_checks++;
    if (s_en !== 1'b0) begin n_errors++; $display("FAIL misalign_pulse_en: got %b, expected 0", s_en); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'h0);
      n_checks++;
      if (s_fault !== 1'b1 || s_en !== 1'b0 || s_valid !== 1'b0) begin
        n_errors++; $display("FAIL misalign_fault +%0d: fault=%b en=%b valid=%b, expected 1 0 0", i + 1, s_fault, s_en, s_valid);
      end
    end
    drive(1'b1, 1'b1, 32'h2000);
    drive(1'b1, 1'b0, 32'h0);
    n_checks++;
    if (s_fault !== 1'b1 || s_en !== 1'b0) begin n_errors++; $display("FAIL oob_fault: fault=%b en=%b, expected 1 0", s_fault, s_en); end
    drive(1'b1, 1'b1, 32'h40);
    n_checks++;
    if (s_en !== 1'b0 || s_fault !== 1'b1) begin n_errors++; $display("FAIL recover_pulse: en=%b fault=%b, expected 0 1", s_en, s_fault); end
    drive(1'b1, 1'b0, 32'h0);
    n_checks++;
    if (s_fault !== 1'b0 || s_en !== 1'b1 || s_addr !== 32'h40) begin
      n_errors++; $display("FAIL recover_issue: fault=%b en=%b addr=%h, expected 0 1 40", s_fault, s_en, s_addr);
    end
    repeat (2) drive(1'b1, 1'b0, 32'h0);
    n_checks++;
    if (s_valid !== 1'b1 || s_pc !== 32'h40 || s_instr !== rom_word(32'h40)) begin
      n_errors++; $display("FAIL recover_deliver: valid=%b pc=%h instr=%h, expected 1 40 %h", s_valid, s_pc, s_instr, rom_word(32'h40));
    end
  endtask

  task automatic test_end_of_rom;
    int          n_iss, n_del;
    logic [31:0] e_addr;
    drive(1'b1, 1'b1, 32'h1FF8);
    n_iss = 0; n_del = 0;
    for (int i = 1; i <= 12; i++) begin
      drive(1'b1, 1'b0, 32'h0);
      if (s_en) begin
        e_addr = 32'h1FF8 + 32'(4 * n_iss);
        n_checks++;
        if (s_addr !== e_addr || s_addr > 32'h1FFC) begin n_errors++; $display("FAIL eor_issue: got %h, expected %h (max 1ffc)", s_addr, e_addr); end
        n_iss++;
      end
      if (s_valid) begin
        e_addr = 32'h1FF8 + 32'(4 * n_del);
        n_checks++;
        if (s_pc !== e_addr || s_instr !== rom_word(e_addr)) begin n_errors++; $display("FAIL eor_deliver: pc=%h instr=%h, expected %h %h", s_pc, s_instr, e_addr, rom_word(e_addr)); end
        n_del++;
      end
      if (i == 4) begin
        n_checks++;
        if (s_fault !== 1'b0) begin n_errors++; $display("FAIL eor_early_fault: got %b, expected 0", s_fault); end
      end
    end
    n_checks++;
    if (n_iss != 2) begin n_errors++; $display("FAIL eor_issue_count: got %0d, expected 2", n_iss); end
    n_checks++;
    if (n_del != 2) begin n_errors++; $display("FAIL eor_deliver_count: got %0d, expected 2", n_del); end
    n_checks++;
    if (s_fault !== 1'b1 || s_en !== 1'b0 || s_valid !== 1'b0) begin
      n_errors++; $display("FAIL eor_final: fault=%b en=%b valid=%b, expected 1 0 0", s_fault, s_en, s_valid);
    end
  endtask

  // Model: n_out = issued minus delivered; a new request is allowed while
  // n_out < FIFO_DEPTH; the newest request is not yet visible to the consumer.
  task automatic test_random_stream;
    logic [31:0] exp_pc, exp_issue, prev_pc, prev_instr, tgt;
    int          n_out;
    logic        last_issued, hold_prev, rdy, redir, exp_en, exp_valid;
    tgt = 32'($urandom_range(0, 1023)) * 32'd4;
    drive(1'b0, 1'b1, tgt);
    exp_pc = tgt; exp_issue = tgt; n_out = 0; last_issued = 1'b0; hold_prev = 1'b0;
    prev_pc = '0; prev_instr = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      rdy   = ($urandom_range(0, 9) < 7);
      redir = ($urandom_range(0, 24) == 0);
      tgt   = 32'($urandom_range(0, 1023)) * 32'd4;
      drive(rdy, redir, tgt);
      exp_en    = !redir && (n_out < FIFO_DEPTH);
      exp_valid = (n_out - int'(last_issued)) > 0;
      n_checks++;
      if (s_en !== exp_en || (exp_en && s_addr !== exp_issue)) begin
        n_errors++; $display("FAIL rand_issue cyc%0d: en=%b addr=%h, expected %b %h", cyc, s_en, s_addr, exp_en, exp_issue);
      end
      n_checks++;
      if (s_valid !== exp_valid) begin n_errors++; $display("FAIL rand_valid cyc%0d: got %b, expected %b", cyc, s_valid, exp_valid); end
      if (hold_prev) begin
        n_checks++;
        if (s_pc !== prev_pc || s_instr !== prev_instr) begin
          n_errors++; $display("FAIL rand_hold cyc%0d: pc=%h instr=%h, expected %h %h", cyc, s_pc, s_instr, prev_pc, prev_instr);
        end
      end
      if (exp_valid && rdy) begin
        n_checks++;
        if (s_pc !== exp_pc || s_instr !== rom_word(exp_pc)) begin
          n_errors++; $display("FAIL rand_deliver cyc%0d: pc=%h instr=%h, expected %h %h", cyc, s_pc, s_instr, exp_pc, rom_word(exp_pc));
        end
        exp_pc += 32'd4;
        n_out--;
      end
      if (exp_en) begin
        exp_issue += 32'd4;
        n_out++;
      end
      last_issued = exp_en;
      hold_prev   = exp_valid && !rdy && !redir;
      prev_pc     = s_pc;
      prev_instr  = s_instr;
      if (redir) begin
        exp_pc = tgt; exp_issue = tgt; n_out = 0; last_issued = 1'b0;
      end
    end
  endtask

  task automatic test_reset_midstream;
    drive(1'b1, 1'b1, 32'h300);
    repeat (5) drive(1'b1, 1'b0, 32'h0);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (rom_en_o !== 1'b0 || rom_addr_o !== RESET_PC) begin
      n_errors++; $display("FAIL midreset_rom: en=%b addr=%h, expected 0 %h", rom_en_o, rom_addr_o, RESET_PC);
    end
    n_checks++;
    if (instr_valid_o !== 1'b0 || fault_o !== 1'b0) begin
      n_errors++; $display("FAIL midreset_out: valid=%b fault=%b, expected 0 0", instr_valid_o, fault_o);
    end
    test_startup;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_startup;
    test_backpressure;
    test_redirect_inflight;
    test_fault;
    test_end_of_rom;
    test_random_stream;
    test_reset_midstream;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
